// File: rtl/gpio_seg_display.sv
// gpio_seg_display: 8-digit multiplexed 7-seg driver for the GPIO word; GPIO_SEG_BCD_EN selects decimal display
module gpio_seg_display #(
  parameter int SCAN_DIV = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value_in,
  input  logic        en_in,
  output logic [6:0]  seg_out,
  output logic        dp_out,
  output logic [7:0]  an_out,
  output logic        busy_out
);
  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  logic [PW-1:0] pre;
  logic [2:0]    idx;
  logic [31:0]   snap, disp;
  logic          idle, load, wrap;
  assign wrap = pre == PW'(SCAN_DIV - 1);
  assign load = idle && value_in != snap;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pre     <= '0;
      idx     <= '0;
      snap    <= '0;
      seg_out <= 7'h7F;
      an_out  <= 8'hFF;
    end else begin
      pre     <= wrap ? '0 : pre + PW'(1);
      idx     <= wrap ? idx + 3'd1 : idx;
      if (load) snap <= value_in;
      an_out  <= en_in ? ~(8'd1 << idx) : 8'hFF;
      seg_out <= en_in ? HEX[disp[4*idx +: 4]] : 7'h7F;
    end
`ifdef GPIO_SEG_BCD_EN
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t      state, state_nx;
  logic [39:0] acc;
  logic [38:0] adj;
  logic [4:0]  cnt;
  logic        ovf;
  assign idle     = state == IDLE;
  assign busy_out = !idle;
  // The top BCD digit of any 32-bit prefix is at most 4, so it never needs the +3 fix-up
  always_comb begin
    state_nx = state;
    if (state == IDLE && load) state_nx = SHIFT;
    if (state == SHIFT && cnt == 5'd31) state_nx = DONE;
    if (state == DONE) state_nx = IDLE;
    adj = acc[38:0];
    for (int i = 0; i < 9; i++)
      adj[4*i +: 4] = acc[4*i +: 4] >= 4'd5 ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      disp   <= '0;
      dp_out <= 1'b1;
    end else begin
      state  <= state_nx;
      dp_out <= !(en_in && ovf && idx == 3'd7);
      if (load) begin
        acc <= '0;
        cnt <= '0;
      end
      if (state == SHIFT) begin
        acc <= {adj, snap[5'd31 - cnt]};
        cnt <= cnt + 5'd1;
      end
      if (state == DONE) begin
        disp <= acc[31:0];
        ovf  <= |acc[39:32];
      end
    end
`else
  assign idle     = 1'b1;
  assign busy_out = 1'b0;
  assign dp_out   = 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) disp <= '0;
    else if (load) disp <= value_in;
`endif
endmodule

// File: tb/tb_gpio_seg_display.sv
// tb_gpio_seg_display: directed self-checking bench for gpio_seg_display with SCAN_DIV = 4
module tb_gpio_seg_display;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] value_in = '0;
  logic        en_in = 1'b1;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [7:0]  an_out;
  logic        busy_out;
  int passed = 0;
  int total = 0;
  int nfail = 0;
  localparam logic [6:0] HEXT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  gpio_seg_display #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .value_in(value_in), .en_in(en_in),
    .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out), .busy_out(busy_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wait_an(input int d);
    logic [7:0] a;
    int n;
    a = ~(8'd1 << d);
    n = 0;
    while (an_out !== a && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("an_wait", {32'd0, an_out}, {32'd0, a});
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    while (busy_out === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask
`ifdef GPIO_SEG_BCD_EN
  task automatic show_check(input logic [31:0] digits, input logic ovf);
    for (int d = 7; d >= 0; d--) begin
      wait_an(d);
      chk("bcd_seg", {33'd0, seg_out}, {33'd0, HEXT[digits[4*d +: 4]]});
      chk("bcd_dp", {39'd0, dp_out}, {39'd0, !(ovf && d == 7)});
    end
  endtask
`endif
  initial begin
    int n;
    logic [31:0] v;
    logic [7:0] a;
    repeat (2) @(negedge clk);
    chk("rst_seg", {33'd0, seg_out}, {33'd0, 7'h7F});
    chk("rst_an", {32'd0, an_out}, {32'd0, 8'hFF});
    chk("rst_dp", {39'd0, dp_out}, 40'd1);
    chk("rst_busy", {39'd0, busy_out}, 40'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_an", {32'd0, an_out}, {32'd0, 8'hFE});
    chk("first_seg", {33'd0, seg_out}, {33'd0, 7'b1000000});
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_seg", {33'd0, seg_out}, {33'd0, 7'h7F});
    chk("async_an", {32'd0, an_out}, {32'd0, 8'hFF});
    chk("async_dp", {39'd0, dp_out}, 40'd1);
    @(negedge clk);
    rst = 1'b0;
`ifndef GPIO_SEG_BCD_EN
    v = 32'h1234ABCD;
    value_in = v;
    repeat (2) @(negedge clk);
    chk("hex_an0", {32'd0, an_out}, {32'd0, 8'hFE});
    chk("hex_seg0", {33'd0, seg_out}, {33'd0, 7'b0100001});
    repeat (2) @(negedge clk);
    chk("hex_an0_end", {32'd0, an_out}, {32'd0, 8'hFE});
    for (int d = 1; d < 8; d++) begin
      a = ~(8'd1 << d);
      @(negedge clk);
      chk("hex_an_start", {32'd0, an_out}, {32'd0, a});
      repeat (3) @(negedge clk);
      chk("hex_an_end", {32'd0, an_out}, {32'd0, a});
      chk("hex_seg", {33'd0, seg_out}, {33'd0, HEXT[v[4*d +: 4]]});
    end
    chk("hex_seg4_const", {33'd0, HEXT[v[19:16]]}, {33'd0, 7'b0011001});
    chk("hex_busy", {39'd0, busy_out}, 40'd0);
    chk("hex_dp", {39'd0, dp_out}, 40'd1);
    repeat (2) @(negedge clk);
    en_in = 1'b0;
    @(negedge clk);
    chk("en_off_an", {32'd0, an_out}, {32'd0, 8'hFF});
    chk("en_off_seg", {33'd0, seg_out}, {33'd0, 7'h7F});
    chk("en_off_dp", {39'd0, dp_out}, 40'd1);
    repeat (6) @(negedge clk);
    chk("en_off_hold", {32'd0, an_out}, {32'd0, 8'hFF});
    en_in = 1'b1;
    @(negedge clk);
    chk("en_resume_an", {32'd0, an_out}, {32'd0, 8'hFB});
    chk("en_resume_seg", {33'd0, seg_out}, {33'd0, 7'b0000011});
`else
    value_in = 32'd12345678;
    @(negedge clk);
    chk("bcd_busy_rise", {39'd0, busy_out}, 40'd1);
    wait_idle(n);
    chk("bcd_busy_len", 40'(n), 40'd33);
    show_check(32'h12345678, 1'b0);
    value_in = 32'hFFFFFFFF;
    @(negedge clk);
    wait_idle(n);
    chk("ovf_busy_len", 40'(n), 40'd33);
    show_check(32'h94967295, 1'b1);
    value_in = 32'd5;
    repeat (10) @(negedge clk);
    value_in = 32'd77;
    repeat (24) @(negedge clk);
    chk("chg_first_busy", {39'd0, busy_out}, 40'd0);
    chk("chg_first_disp", {8'd0, dut.disp}, 40'h5);
    @(negedge clk);
    chk("chg_restart", {39'd0, busy_out}, 40'd1);
    repeat (32) @(negedge clk);
    chk("chg_not_yet", {8'd0, dut.disp}, 40'h5);
    chk("chg_busy_32", {39'd0, busy_out}, 40'd1);
    @(negedge clk);
    chk("chg_final_disp", {8'd0, dut.disp}, 40'h77);
    chk("chg_final_busy", {39'd0, busy_out}, 40'd0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
